atd_tx_block: RTL and testbench

Serializer for the ATD serial link: accepts a 128-bit word over a valid/ready handshake and shifts it out MSB-first on ATD_data, with a self-generated ATD_clk. It sits on the transmit side of the link, mirroring the ATD receive path (synchronizer, edge detector, shift-to-parallel, data_ready/data_taken). All timing derives from the system clock, so the receiver's two-flop synchronizers see clean, wide phases.

---
 rtl/atd_tx_block.sv | 158 +++++++++++++++
 tb/tb_atd_tx_block.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/atd_tx_block.sv
// ---------------------------------------------------------------------------
// atd_tx_block
//
// Transmit-side serializer for the ATD serial link. A 128-bit word accepted
// over a valid/ready handshake is shifted out MSB-first on ATD_data, together
// with a self-generated ATD_clk. Every phase of ATD_clk is CLK_DIV system
// clocks long, so the receiver's two-flop synchronizers see wide, clean
// phases. Each frame is followed by GAP_CYCLES idle cycles before tx_done.
//
// Parameters
//   CLK_DIV     system clocks per ATD_clk phase (low or high), 3..255
//   GAP_CYCLES  idle system clocks after each frame, 1..1023
//
// Ports
//   clk       in   system clock, rising edge
//   n_rst     in   asynchronous active-low reset
//   tx_data   in   [127:0] word to send, sampled only on accept
//   tx_valid  in   upstream has a word
//   tx_ready  out  block can accept (high only while idle)
//   tx_done   out  one-cycle pulse when a frame and its gap complete
//   ATD_data  out  serial data, registered
//   ATD_clk   out  serial clock, registered
//
// Build option
//   ATD_TX_PARITY_EN  when defined, one odd-parity bit (~^tx_data, captured
//                     at accept) follows bit 0, giving a 129-bit frame.
//                     When undefined no parity logic exists.
// ---------------------------------------------------------------------------
module atd_tx_block #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [127:0] tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    output logic         tx_done,
    output logic         ATD_data,
    output logic         ATD_clk
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [9:0] GAP_LAST = 10'(GAP_CYCLES - 1);

`ifdef ATD_TX_PARITY_EN
    // 129 bits on the wire: bit counter runs 0..128.
    localparam logic [7:0] BIT_LAST = 8'd128;
`else
    localparam logic [7:0] BIT_LAST = 8'd127;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t       state;
    // Holds the bits still waiting to go on the wire, next bit at [127].
    // The bit currently on the line lives only in the ATD_data register.
    logic [127:0] shreg;
    logic [7:0]   bit_cnt;
    logic [7:0]   div_cnt;
    logic [9:0]   gap_cnt;
    logic         tail_bit;   // bit loaded behind tx_data[0] at accept

`ifdef ATD_TX_PARITY_EN
    // Odd parity over the data word: total ones in the frame is odd.
    assign tail_bit = ~^tx_data;
`else
    assign tail_bit = 1'b0;
`endif

    // Single registered FSM. All outputs are flops updated on the same edge
    // as the state, so nothing combinational reaches an output pin.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            gap_cnt  <= '0;
            tx_ready <= 1'b0;
            tx_done  <= 1'b0;
            ATD_data <= 1'b0;
            ATD_clk  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    ATD_clk  <= 1'b0;
                    ATD_data <= 1'b0;
                    if (tx_valid && tx_ready) begin
                        // First bit goes on the line right away; the rest
                        // (plus parity, if built) queue up in shreg.
                        shreg    <= {tx_data[126:0], tail_bit};
                        ATD_data <= tx_data[127];
                        bit_cnt  <= '0;
                        div_cnt  <= '0;
                        tx_ready <= 1'b0;
                        state    <= LOW;
                    end else begin
                        // Also raises ready on the first edge after reset.
                        tx_ready <= 1'b1;
                    end
                end

                LOW: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        ATD_clk <= 1'b1;
                        state   <= HIGH;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                HIGH: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        ATD_clk <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            ATD_data <= 1'b0;
                            gap_cnt  <= '0;
                            state    <= GAP;
                        end else begin
                            // Data only moves together with the falling
                            // ATD_clk, never while it is high.
                            bit_cnt  <= bit_cnt + 8'd1;
                            ATD_data <= shreg[127];
                            shreg    <= {shreg[126:0], 1'b0};
                            state    <= LOW;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        // Ready and done rise together so a held tx_valid
                        // is accepted on the very next edge.
                        tx_ready <= 1'b1;
                        tx_done  <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 10'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atd_tx_block.sv
module tb_atd_tx_block;

    localparam int D = 3;
    localparam int G = 16;
`ifdef ATD_TX_PARITY_EN
    localparam int NB = 129;
`else
    localparam int NB = 128;
`endif

    logic         clk = 1'b0;
    logic         n_rst;
    logic [127:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         tx_done;
    logic         ATD_data;
    logic         ATD_clk;

    int checks = 0;
    int errors = 0;

    atd_tx_block #(.CLK_DIV(D), .GAP_CYCLES(G)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .ATD_data (ATD_data),
        .ATD_clk  (ATD_clk)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL global_timeout observed hang expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Sends one word and follows the line until tx_done. The task starts and
    // ends at a falling clk edge. If tx_valid is already high on entry the
    // word is assumed to be on tx_data already (back-to-back case).
    task automatic run_frame(input logic [127:0] w, input bit hold_next,
                             input logic [127:0] next_w, input bit toggle);
        bit           exp_bits[$];
        bit           rx[$];
        logic [127:0] got;
        int           ncyc, nrise, first_rise, last_rise, bad;
        bit           done, prev_clk, prev_data, per_ok, stable_ok, ready_ok;

        // Reference frame: data MSB first, then odd parity if built.
        for (int i = 127; i >= 0; i--) exp_bits.push_back(w[i]);
`ifdef ATD_TX_PARITY_EN
        exp_bits.push_back(($countones(w) % 2) == 0);
`endif

        if (!tx_valid) begin
            for (int t = 0; t < 4000 && !tx_ready; t++) @(negedge clk);
            chk("ready_wait", tx_ready, 1'b1);
            tx_data  = w;
            tx_valid = 1'b1;
        end
        @(negedge clk);   // accept edge has passed
        if (!toggle) tx_valid = 1'b0;
        chk("first_ready", tx_ready, 1'b0);
        chk("first_data",  ATD_data, w[127]);
        chk("first_clk",   ATD_clk,  1'b0);
        chk("done_single", tx_done,  1'b0);

        ncyc = 1; nrise = 0; first_rise = 0; last_rise = 0;
        done = 0; per_ok = 1; stable_ok = 1; ready_ok = 1;
        prev_clk = ATD_clk; prev_data = ATD_data;
        while (!done && ncyc < NB * 2 * D + G + 40) begin
            @(negedge clk);
            ncyc++;
            if (toggle) tx_data = rnd128();
            if (ATD_clk && !prev_clk) begin
                rx.push_back(ATD_data);
                if (nrise == 0) first_rise = ncyc;
                else if (ncyc - last_rise != 2 * D) per_ok = 0;
                last_rise = ncyc;
                nrise++;
            end
            if (ATD_clk && ATD_data != prev_data) stable_ok = 0;
            if (tx_done) done = 1;
            else if (tx_ready) ready_ok = 0;
            prev_clk = ATD_clk; prev_data = ATD_data;
        end

        chk("done_seen",  done, 1'b1);
        chk("latency",    ncyc, NB * 2 * D + G + 1);
        chk("rise_count", nrise, NB);
        chk("first_rise", first_rise, D + 1);
        chk("period",     per_ok, 1'b1);
        chk("data_stable_clk_high", stable_ok, 1'b1);
        chk("ready_low_in_frame",   ready_ok, 1'b1);
        chk("done_ready", tx_ready, 1'b1);
        chk("done_clk",   ATD_clk,  1'b0);
        chk("done_data",  ATD_data, 1'b0);
        bad = 0;
        got = '0;
        for (int i = 0; i < NB; i++) begin
            if (i >= rx.size() || rx[i] != exp_bits[i]) bad++;
            if (i < 128 && i < rx.size()) got[127 - i] = rx[i];
        end
        chk("stream_bits", bad, 0);
        chk("recovered_word", got, w);

        if (hold_next) begin
            tx_data  = next_w;
            tx_valid = 1'b1;
        end else begin
            tx_valid = 1'b0;
        end
    endtask

    initial begin
        logic [127:0] w1, w2;
        int           nrise;
        bit           prev;

        n_rst = 1'b0; tx_valid = 1'b0; tx_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", tx_ready, 1'b0);
        chk("rst_done",  tx_done,  1'b0);
        chk("rst_data",  ATD_data, 1'b0);
        chk("rst_clk",   ATD_clk,  1'b0);
        n_rst = 1'b1;
        @(negedge clk);
        chk("ready_after_release", tx_ready, 1'b1);
        chk("done_after_release",  tx_done,  1'b0);

        // Marker bits at both ends of the stream.
        run_frame(128'h8000_0000_0000_0000_0000_0000_0000_0001, 1'b0, '0, 1'b0);

        // Back-to-back with tx_valid held across tx_done.
        w1 = {64{2'b10}};
        w2 = {64{2'b01}};
        run_frame(w1, 1'b1, w2, 1'b0);
        run_frame(w2, 1'b0, '0, 1'b0);

        // tx_valid high and tx_data churning during a frame.
        w1 = rnd128();
        w2 = rnd128();
        tx_data = w1; tx_valid = 1'b0;
        run_frame(w1, 1'b1, w2, 1'b1);
        run_frame(w2, 1'b0, '0, 1'b0);

        // Reset in the middle of a frame after 40 bits.
        for (int t = 0; t < 4000 && !tx_ready; t++) @(negedge clk);
        tx_data = '1; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        nrise = 0; prev = ATD_clk;
        for (int t = 0; t < 4000 && nrise < 40; t++) begin
            @(negedge clk);
            if (ATD_clk && !prev) nrise++;
            prev = ATD_clk;
        end
        chk("pre_rst_rises", nrise, 40);
        chk("pre_rst_clk",   ATD_clk,  1'b1);
        chk("pre_rst_data",  ATD_data, 1'b1);
        #1 n_rst = 1'b0;
        #1;
        chk("midrst_clk",   ATD_clk,  1'b0);
        chk("midrst_data",  ATD_data, 1'b0);
        chk("midrst_ready", tx_ready, 1'b0);
        chk("midrst_done",  tx_done,  1'b0);
        repeat (2) @(negedge clk);
        chk("midrst_hold_clk", ATD_clk, 1'b0);
        n_rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready_rise", tx_ready, 1'b1);
        chk("midrst_no_done",    tx_done,  1'b0);
        run_frame(rnd128(), 1'b0, '0, 1'b0);

        // Parity-sensitive words (also plain frames without parity).
        run_frame(128'h7, 1'b0, '0, 1'b0);
        run_frame(128'h3, 1'b0, '0, 1'b0);

        // Random loopback frames.
        for (int n = 0; n < 50; n++) run_frame(rnd128(), 1'b0, '0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
